// File: rtl/fifo_push_ctl.sv
// Push-side controller: 2-entry skid buffer feeding a downstream FIFO,
// with a local credit counter refilled by per-entry pop returns.
module fifo_push_ctl #(
  parameter int WIDTH       = 32,
  parameter int PTR_WIDTH   = 7,
  parameter int CREDIT_INIT = 1 << PTR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               push,
  output logic [WIDTH-1:0]   push_data,
  input  logic               pop_ret,
  output logic [PTR_WIDTH:0] credits,
  output logic [1:0]         skid_cnt,
  output logic               cred_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_e;

  localparam logic [PTR_WIDTH:0] CRED_MAX =
    CREDIT_INIT[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH+1:0] CRED_MAX_X =
    {1'b0, CRED_MAX};

  skid_e                state;
  skid_e                state_nxt;
  logic                 accept;
  logic [WIDTH-1:0]     head_q;
  logic [WIDTH-1:0]     tail_q;
  logic [PTR_WIDTH+1:0] cred_sum;
  logic                 cred_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (accept) state_nxt = ONE;
      end
      ONE: begin
        unique case (1'b1)
          accept & ~push: state_nxt = TWO;
          push & ~accept: state_nxt = EMPTY;
          default:        state_nxt = ONE;
        endcase
      end
      TWO: begin
        if (push) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // push depends only on flops, never on in_valid or pop_ret
  always_comb begin
    accept    = in_valid & in_ready;
    push      = (state != EMPTY) & (credits != '0);
    push_data = head_q;
    skid_cnt  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (accept & ((state == EMPTY) | push)) begin
        head_q <= in_data;
      end else if (push & (state == TWO)) begin
        head_q <= tail_q;
      end
      if (accept & (state == ONE) & ~push) begin
        tail_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= (state_nxt != TWO);
    end
  end

  // one extra bit exposes a return beyond the initial credit pool
  always_comb begin
    cred_sum = {1'b0, credits}
             - {{(PTR_WIDTH+1){1'b0}}, push}
             + {{(PTR_WIDTH+1){1'b0}}, pop_ret};
    cred_ovf = cred_sum > CRED_MAX_X;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits  <= CRED_MAX;
      cred_err <= 1'b0;
    end else begin
      credits <= cred_ovf ? CRED_MAX : cred_sum[PTR_WIDTH:0];
      if (cred_ovf) cred_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_push_ctl.sv
// Scoreboard bench for fifo_push_ctl: queue of accepted beats,
// downstream occupancy model, directed corner cases and random traffic.
module tb_fifo_push_ctl;

  localparam int W  = 32;
  localparam int PW = 7;
  localparam int CI = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          push;
  logic [W-1:0]  push_data;
  logic          pop_ret = 1'b0;
  logic [PW:0]   credits;
  logic [1:0]    skid_cnt;
  logic          cred_err;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  sb_q[$];
  int            occ = 0;
  bit            err_m = 0;
  bit            armed = 0;
  bit            last_acc = 0;
  int            n_push = 0;
  int            max_skid = 0;
  logic [W-1:0]  dcnt = '0;
  bit            want_first = 0;
  logic [W-1:0]  first_push = '0;

  fifo_push_ctl #(
    .WIDTH(W),
    .PTR_WIDTH(PW),
    .CREDIT_INIT(CI)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .push(push),
    .push_data(push_data),
    .pop_ret(pop_ret),
    .credits(credits),
    .skid_cnt(skid_cnt),
    .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: at the falling edge, predict and check what the next
  // rising edge will do, then advance the reference model.
  always @(negedge clk) begin
    logic [W-1:0] exp_d;
    if (!rst_n) begin
      sb_q.delete();
      occ      = 0;
      err_m    = 0;
      armed    = 0;
      last_acc = 0;
    end else begin
      chk("skid_cnt", skid_cnt, sb_q.size());
      chk("in_ready", in_ready, armed && sb_q.size() < 2);
      chk("credits", credits, CI - occ);
      chk("push", push, sb_q.size() != 0 && occ < CI);
      chk("cred_err", cred_err, err_m);
      if (push) begin
        n_push++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL push_no_beat actual=%0h expected=none",
                   push_data);
        end else begin
          exp_d = sb_q.pop_front();
          chk("push_data", push_data, exp_d);
        end
        if (want_first) begin
          first_push = push_data;
          want_first = 0;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
      last_acc = in_valid && in_ready;
      if (pop_ret && occ == 0 && !push) err_m = 1;
      else occ = occ + int'(push) - int'(pop_ret);
      if (int'(skid_cnt) > max_skid) max_skid = int'(skid_cnt);
      armed = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (last_acc) dcnt = dcnt + 1;
    in_data = dcnt;
  endtask

  initial begin
    int b;
    int p0;
    int pct;

    // fill from reset with no credit return
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = dcnt;
    b = 0;
    while (n_push < CI && b < 400) begin
      cyc();
      b++;
    end
    chk("fill_budget", n_push, CI);
    repeat (4) cyc();
    chk("stall_pushes", n_push, CI);
    chk("stall_credits", credits, 0);
    chk("stall_skid", skid_cnt, 2);
    chk("stall_ready", in_ready, 0);
    chk("stall_push", push, 0);
    chk("stall_head", push_data, CI);

    // one credit back releases exactly one beat
    in_valid = 1'b0;
    pop_ret = 1'b1;
    cyc();
    pop_ret = 1'b0;
    chk("ret_credits", credits, 1);
    chk("ret_push", push, 1);
    chk("ret_data", push_data, CI);
    cyc();
    chk("ret_skid", skid_cnt, 1);
    chk("ret_ready", in_ready, 1);
    chk("ret_credits0", credits, 0);
    chk("ret_push0", push, 0);

    // refill skid, then reset mid-cycle
    in_valid = 1'b1;
    repeat (3) cyc();
    chk("pre_rst_skid", skid_cnt, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_push", push, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_skid", skid_cnt, 0);
    chk("arst_credits", credits, CI);
    chk("arst_err", cred_err, 0);
    repeat (2) @(posedge clk);
    #1;
    dcnt = 32'd1000;
    in_data = dcnt;
    want_first = 1;
    rst_n = 1'b1;
    repeat (20) cyc();
    chk("first_after_rst", first_push, 1000);

    // drain everything
    in_valid = 1'b0;
    repeat (300) begin
      cyc();
      pop_ret = occ > 0;
    end
    pop_ret = 1'b0;
    cyc();
    chk("drained_credits", credits, CI);

    // spurious return while idle and full of credit
    pop_ret = 1'b1;
    cyc();
    pop_ret = 1'b0;
    chk("spur_err", cred_err, 1);
    chk("spur_credits", credits, CI);

    // same case but with a push in the same cycle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    pop_ret = 1'b1;
    chk("pp_push", push, 1);
    chk("pp_credits", credits, CI);
    cyc();
    pop_ret = 1'b0;
    chk("pp_err", cred_err, 0);
    chk("pp_credits_after", credits, CI);

    // steady streaming with matching returns
    in_valid = 1'b1;
    repeat (5) begin
      cyc();
      pop_ret = occ > 0;
    end
    p0 = n_push;
    max_skid = 0;
    repeat (40) begin
      cyc();
      pop_ret = occ > 0;
    end
    chk("steady_pushes", n_push - p0, 40);
    chk("steady_skid", max_skid <= 1, 1);
    chk("steady_credits", credits, CI - 1);

    // random traffic with bursty credit return
    for (int i = 0; i < 10000; i++) begin
      cyc();
      pct = ((i / 1000) % 2 != 0) ? 30 : 90;
      in_valid = ($urandom % 4) != 0;
      pop_ret = occ > 0 && ($urandom % 100) < pct;
    end
    in_valid = 1'b0;
    pop_ret = 1'b0;
    cyc();
    chk("rand_err", cred_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
